// File: rtl/uart_core_fifo.sv
// Avalon-MM UART with TX/RX FIFOs, runtime divisor, optional parity, 1/2 stop bits,
// sticky error flags and a maskable level interrupt.
module uart_core_fifo #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic [3:0] avms_address_i,
    input  logic       avms_read_i,
    input  logic       avms_write_i,
    input  logic [7:0] avms_writedata_i,
    output logic [7:0] avms_readdata_o,
    output logic       uart_txd_o,
    input  logic       uart_rxd_i,
    output logic       IRQ_event
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT   = (AW + 1)'(1);
    localparam logic [15:0] RESET_DIV = 16'(CLK_FREQ / BAUD_RATE);
    localparam logic [3:0]  DW_LAST   = 4'(DATA_W - 1);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    logic [15:0] div_q;
    logic [2:0]  ctrl_q;
    logic [2:0]  irq_en_q;
    logic        rx_overrun_q, frame_err_q, parity_err_q, tx_overflow_q;
    logic [7:0]  rdata_q;
    logic        irq_q;

    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wr_q, tx_rd_q, tx_rd_nxt;
    logic [AW:0]       tx_cnt_q;
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     rx_wr_q, rx_rd_q;
    logic [AW:0]       rx_cnt_q;

    tx_state_e         tx_state_q;
    logic [15:0]       tx_baud_q;
    logic [3:0]        tx_bit_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic              tx_par_q, tx_stop_q, txd_q;

    rx_state_e         rx_state_q;
    logic [15:0]       rx_baud_q;
    logic [3:0]        rx_bit_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic              rx_par_bad_q, rx_brk_q;
    logic              rx_s1_q, rx_s2_q, rx_prev_q;

    logic        wr_en, rd_en;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
    logic        tx_idle, err_any, rx_done, rx_stop_low;
    logic        tx_bit_end, rx_bit_end, rx_fall;
    logic [15:0] eff_div;
    logic [7:0]  status, sticky_clr;
    logic [DATA_W-1:0] tx_head, tx_next;

    assign wr_en       = avms_write_i;
    assign rd_en       = avms_read_i & ~avms_write_i;
    assign tx_full     = (tx_cnt_q == FULL_CNT);
    assign tx_empty    = (tx_cnt_q == '0);
    assign rx_full     = (rx_cnt_q == FULL_CNT);
    assign rx_empty    = (rx_cnt_q == '0);
    assign eff_div     = (div_q < 16'd4) ? 16'd4 : div_q;
    assign tx_rd_nxt   = tx_rd_q + AW'(1);
    assign tx_head     = tx_mem[tx_rd_q];
    assign tx_next     = tx_mem[tx_rd_nxt];
    assign tx_bit_end  = (tx_baud_q == 16'd0);
    assign rx_bit_end  = (rx_baud_q == 16'd0);
    assign rx_fall     = rx_prev_q & ~rx_s2_q;

    // The in-flight character stays at the FIFO head until its last stop bit ends.
    assign tx_pop      = (tx_state_q == TxStop) && tx_bit_end && (!ctrl_q[2] || tx_stop_q);
    assign tx_push_req = wr_en && (avms_address_i == 4'h0);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign rx_pop      = rd_en && (avms_address_i == 4'h2) && !rx_empty;
    assign rx_done     = (rx_state_q == RxStop) && !rx_brk_q && rx_bit_end && rx_s2_q;
    assign rx_stop_low = (rx_state_q == RxStop) && !rx_brk_q && rx_bit_end && !rx_s2_q;
    assign rx_push     = rx_done && (!rx_full || rx_pop);

    assign tx_idle    = tx_empty && (tx_state_q == TxIdle);
    assign err_any    = rx_overrun_q | frame_err_q | parity_err_q | tx_overflow_q;
    assign status     = {1'b0, tx_overflow_q, parity_err_q, frame_err_q, rx_overrun_q,
                         tx_idle, ~rx_empty, ~tx_full};
    assign sticky_clr = (wr_en && avms_address_i == 4'h1) ? avms_writedata_i : 8'h00;

    assign avms_readdata_o = rdata_q;
    assign uart_txd_o      = txd_q;
    assign IRQ_event       = irq_q;

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_q] <= avms_writedata_i[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wr_q] <= rx_shift_q;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_nxt;
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + ONE_CNT;
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - ONE_CNT;
            if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
            if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + ONE_CNT;
            else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - ONE_CNT;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            div_q         <= RESET_DIV;
            ctrl_q        <= '0;
            irq_en_q      <= '0;
            rx_overrun_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            tx_overflow_q <= 1'b0;
            rdata_q       <= '0;
            irq_q         <= 1'b0;
        end else begin
            if (wr_en) begin
                case (avms_address_i)
                    4'h3:    irq_en_q     <= avms_writedata_i[2:0];
                    4'h4:    ctrl_q       <= avms_writedata_i[2:0];
                    4'h5:    div_q[7:0]   <= avms_writedata_i;
                    4'h6:    div_q[15:8]  <= avms_writedata_i;
                    default: ;
                endcase
            end
            // A new event in the same cycle as a clear wins.
            rx_overrun_q  <= (rx_done && rx_full && !rx_pop) | (rx_overrun_q & ~sticky_clr[3]);
            frame_err_q   <= rx_stop_low | (frame_err_q & ~sticky_clr[4]);
            parity_err_q  <= (rx_done && rx_par_bad_q) | (parity_err_q & ~sticky_clr[5]);
            tx_overflow_q <= (tx_push_req && tx_full && !tx_pop)
                             | (tx_overflow_q & ~sticky_clr[6]);
            if (rd_en) begin
                case (avms_address_i)
                    4'h1:    rdata_q <= status;
                    4'h2:    rdata_q <= rx_empty ? 8'h00 : 8'(rx_mem[rx_rd_q]);
                    4'h3:    rdata_q <= {5'b0, irq_en_q};
                    4'h4:    rdata_q <= {5'b0, ctrl_q};
                    4'h5:    rdata_q <= div_q[7:0];
                    4'h6:    rdata_q <= div_q[15:8];
                    default: rdata_q <= 8'h00;
                endcase
            end
            irq_q <= |(irq_en_q & {err_any, tx_idle, ~rx_empty});
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tx_state_q <= TxIdle;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_stop_q  <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            unique case (tx_state_q)
                TxIdle: begin
                    txd_q <= 1'b1;
                    if (!tx_empty) begin
                        tx_state_q <= TxStart;
                        txd_q      <= 1'b0;
                        tx_shift_q <= tx_head;
                        tx_par_q   <= ^tx_head ^ ctrl_q[1];
                        tx_baud_q  <= eff_div - 16'd1;
                    end
                end
                TxStart: begin
                    if (tx_bit_end) begin
                        tx_state_q <= TxData;
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= '0;
                        tx_baud_q  <= eff_div - 16'd1;
                    end else begin
                        tx_baud_q <= tx_baud_q - 16'd1;
                    end
                end
                TxData: begin
                    if (tx_bit_end) begin
                        tx_baud_q <= eff_div - 16'd1;
                        if (tx_bit_q == DW_LAST) begin
                            tx_state_q <= ctrl_q[0] ? TxParity : TxStop;
                            txd_q      <= ctrl_q[0] ? tx_par_q : 1'b1;
                            tx_stop_q  <= 1'b0;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 4'd1;
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                        end
                    end else begin
                        tx_baud_q <= tx_baud_q - 16'd1;
                    end
                end
                TxParity: begin
                    if (tx_bit_end) begin
                        tx_state_q <= TxStop;
                        txd_q      <= 1'b1;
                        tx_stop_q  <= 1'b0;
                        tx_baud_q  <= eff_div - 16'd1;
                    end else begin
                        tx_baud_q <= tx_baud_q - 16'd1;
                    end
                end
                TxStop: begin
                    if (!tx_bit_end) begin
                        tx_baud_q <= tx_baud_q - 16'd1;
                    end else if (ctrl_q[2] && !tx_stop_q) begin
                        tx_stop_q <= 1'b1;
                        tx_baud_q <= eff_div - 16'd1;
                    end else if (tx_cnt_q > ONE_CNT) begin
                        tx_state_q <= TxStart;
                        txd_q      <= 1'b0;
                        tx_shift_q <= tx_next;
                        tx_par_q   <= ^tx_next ^ ctrl_q[1];
                        tx_baud_q  <= eff_div - 16'd1;
                    end else begin
                        tx_state_q <= TxIdle;
                        txd_q      <= 1'b1;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RxIdle;
            rx_baud_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_bad_q <= 1'b0;
            rx_brk_q     <= 1'b0;
        end else begin
            rx_s1_q   <= uart_rxd_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            unique case (rx_state_q)
                RxIdle: begin
                    if (rx_fall) begin
                        rx_state_q   <= RxStart;
                        rx_baud_q    <= (eff_div >> 1) - 16'd1;
                        rx_par_bad_q <= 1'b0;
                    end
                end
                RxStart: begin
                    if (rx_bit_end) begin
                        rx_state_q <= rx_s2_q ? RxIdle : RxData;
                        rx_bit_q   <= '0;
                        rx_baud_q  <= eff_div - 16'd1;
                    end else begin
                        rx_baud_q <= rx_baud_q - 16'd1;
                    end
                end
                RxData: begin
                    if (rx_bit_end) begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_W-1:1]};
                        rx_baud_q  <= eff_div - 16'd1;
                        if (rx_bit_q == DW_LAST) rx_state_q <= ctrl_q[0] ? RxParity : RxStop;
                        else                     rx_bit_q   <= rx_bit_q + 4'd1;
                    end else begin
                        rx_baud_q <= rx_baud_q - 16'd1;
                    end
                end
                RxParity: begin
                    if (rx_bit_end) begin
                        rx_par_bad_q <= rx_s2_q != (^rx_shift_q ^ ctrl_q[1]);
                        rx_state_q   <= RxStop;
                        rx_baud_q    <= eff_div - 16'd1;
                    end else begin
                        rx_baud_q <= rx_baud_q - 16'd1;
                    end
                end
                RxStop: begin
                    // After a low stop bit, hold here until the line returns high.
                    if (rx_brk_q) begin
                        if (rx_s2_q) begin
                            rx_brk_q   <= 1'b0;
                            rx_state_q <= RxIdle;
                        end
                    end else if (rx_bit_end) begin
                        if (rx_s2_q) rx_state_q <= RxIdle;
                        else         rx_brk_q   <= 1'b1;
                    end else begin
                        rx_baud_q <= rx_baud_q - 16'd1;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core_fifo.sv
// Scoreboard bench for uart_core_fifo: bus reads and serial TX frames are checked by
// monitors against queues of hand-computed expectations filled by the stimulus.
module tb_uart_core_fifo;

    logic       clk_i = 1'b0;
    logic       arst_n_i = 1'b0;
    logic [3:0] avms_address_i = 4'h0;
    logic       avms_read_i = 1'b0;
    logic       avms_write_i = 1'b0;
    logic [7:0] avms_writedata_i = 8'h00;
    logic [7:0] avms_readdata_o;
    logic       uart_txd_o;
    logic       uart_rxd_i = 1'b1;
    logic       irq;

    uart_core_fifo dut (
        .clk_i           (clk_i),
        .arst_n_i        (arst_n_i),
        .avms_address_i  (avms_address_i),
        .avms_read_i     (avms_read_i),
        .avms_write_i    (avms_write_i),
        .avms_writedata_i(avms_writedata_i),
        .avms_readdata_o (avms_readdata_o),
        .uart_txd_o      (uart_txd_o),
        .uart_rxd_i      (uart_rxd_i),
        .IRQ_event       (irq)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic       rd_fire = 1'b0;
    logic [7:0] rd_exp[$];
    logic [7:0] rd_mask[$];
    string      rd_name[$];
    logic [7:0] tx_exp[$];
    int         frame_starts[$];
    int         frames_seen = 0;
    int         tx_div = 868;
    bit         tx_par = 0, tx_odd = 0, tx_stop2 = 0, tx_ignore = 0;

    always @(posedge clk_i) begin
        cyc     <= cyc + 1;
        rd_fire <= avms_read_i && !avms_write_i;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk_i);
        avms_address_i   = addr;
        avms_writedata_i = data;
        avms_write_i     = 1'b1;
        @(negedge clk_i);
        avms_write_i     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] addr, input logic [7:0] exp,
                            input logic [7:0] mask, input string name);
        @(negedge clk_i);
        rd_exp.push_back(exp);
        rd_mask.push_back(mask);
        rd_name.push_back(name);
        avms_address_i = addr;
        avms_read_i    = 1'b1;
        @(negedge clk_i);
        avms_read_i    = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] data, input int d, input bit par_en,
                           input bit par_val, input bit stop_val);
        @(negedge clk_i);
        uart_rxd_i = 1'b0;
        repeat (d) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            uart_rxd_i = data[i];
            repeat (d) @(negedge clk_i);
        end
        if (par_en) begin
            uart_rxd_i = par_val;
            repeat (d) @(negedge clk_i);
        end
        uart_rxd_i = stop_val;
        repeat (d) @(negedge clk_i);
        uart_rxd_i = 1'b1;
    endtask

    task automatic set_div(input logic [15:0] d);
        bus_write(4'h5, d[7:0]);
        bus_write(4'h6, d[15:8]);
    endtask

    // Read-data monitor: one expectation per completed read strobe.
    initial begin : rd_mon
        logic [7:0] e, m;
        string n;
        forever begin
            @(negedge clk_i);
            if (rd_fire) begin
                if (rd_exp.size() == 0) begin
                    check("rd_unexpected", avms_readdata_o, 8'h00);
                end else begin
                    e = rd_exp.pop_front();
                    m = rd_mask.pop_front();
                    n = rd_name.pop_front();
                    check(n, avms_readdata_o & m, e & m);
                end
            end
        end
    end

    // Serial TX monitor: decodes each frame mid-bit and scores the byte and framing.
    initial begin : tx_mon
        logic [7:0] b;
        logic       ok;
        int         d;
        forever begin
            @(negedge clk_i);
            if (uart_txd_o === 1'b0) begin
                d = tx_div;
                frames_seen++;
                frame_starts.push_back(cyc);
                repeat (d / 2) @(negedge clk_i);
                ok = (uart_txd_o === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk_i);
                    b[i] = uart_txd_o;
                end
                if (tx_par) begin
                    repeat (d) @(negedge clk_i);
                    ok = ok && (uart_txd_o === (^b ^ tx_odd));
                end
                repeat (d) @(negedge clk_i);
                ok = ok && (uart_txd_o === 1'b1);
                if (tx_stop2) begin
                    repeat (d) @(negedge clk_i);
                    ok = ok && (uart_txd_o === 1'b1);
                end
                if (!tx_ignore) begin
                    if (tx_exp.size() == 0) check("tx_unexpected_frame", {ok, b}, 9'h000);
                    else check("tx_frame", {ok, b}, {1'b1, tx_exp.pop_front()});
                end
            end
        end
    end

    initial begin : main
        bit found;
        int fs;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_txd", uart_txd_o, 1'b1);
        check("rst_readdata", avms_readdata_o, 8'h00);
        check("rst_irq", irq, 1'b0);
        arst_n_i = 1'b1;
        bus_read(4'h1, 8'h05, 8'hFF, "rst_status");
        bus_read(4'h5, 8'h64, 8'hFF, "rst_div_lo");
        bus_read(4'h6, 8'h03, 8'hFF, "rst_div_hi");
        bus_read(4'h4, 8'h00, 8'hFF, "rst_ctrl");
        bus_read(4'h3, 8'h00, 8'hFF, "rst_irq_en");
        bus_read(4'h2, 8'h00, 8'hFF, "rst_rxdata_empty");
        bus_read(4'h7, 8'h00, 8'hFF, "unmapped_read");

        // Default-rate TX of 0x48: bits 0-2 low, bit3 high -> line rises 4*868 clks after start
        tx_exp.push_back(8'h48);
        bus_write(4'h0, 8'h48);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk_i);
            if (uart_txd_o === 1'b0) found = 1;
        end
        check("tx_start_seen", found, 1'b1);
        if (found) begin
            repeat (3471) @(negedge clk_i);
            check("tx_low_until_bit3", uart_txd_o, 1'b0);
            @(negedge clk_i);
            check("tx_bit3_edge", uart_txd_o, 1'b1);
        end
        repeat (868 * 6 + 100) @(negedge clk_i);
        bus_read(4'h1, 8'h04, 8'h04, "tx_idle_after_frame");

        // RX with interrupt at the reset rate
        bus_write(4'h3, 8'h01);
        repeat (3) @(negedge clk_i);
        check("irq_low_rx_empty", irq, 1'b0);
        send_rx(8'h6E, 868, 0, 0, 1);
        repeat (5) @(negedge clk_i);
        check("irq_rx_not_empty", irq, 1'b1);
        bus_read(4'h2, 8'h6E, 8'hFF, "rx_data_6e");
        repeat (3) @(negedge clk_i);
        check("irq_fall_after_pop", irq, 1'b0);
        bus_read(4'h2, 8'h00, 8'hFF, "rx_second_read_empty");
        bus_write(4'h3, 8'h02);
        repeat (3) @(negedge clk_i);
        check("irq_tx_idle", irq, 1'b1);
        bus_write(4'h3, 8'h00);

        // Glitch: 100-clk low pulse is shorter than half a bit
        @(negedge clk_i);
        uart_rxd_i = 1'b0;
        repeat (100) @(negedge clk_i);
        uart_rxd_i = 1'b1;
        repeat (1200) @(negedge clk_i);
        bus_read(4'h1, 8'h05, 8'hFF, "glitch_no_byte_no_err");

        // Back-to-back TX at 16 clks/bit, FIFO fill and overflow
        set_div(16'd16);
        tx_div = 16;
        frame_starts.delete();
        for (int i = 0; i < 16; i++) begin
            tx_exp.push_back(8'(i));
            bus_write(4'h0, 8'(i));
        end
        bus_read(4'h1, 8'h00, 8'h01, "tx_fifo_full");
        bus_write(4'h0, 8'hAA);
        bus_read(4'h1, 8'h40, 8'h41, "tx_overflow_set");
        repeat (16 * 160 + 100) @(negedge clk_i);
        check("b2b_frame_count", frame_starts.size(), 16);
        for (int i = 1; i < frame_starts.size(); i++)
            check("b2b_no_gap", frame_starts[i] - frame_starts[i-1], 160);
        bus_write(4'h1, 8'h40);
        bus_read(4'h1, 8'h05, 8'hFF, "tx_overflow_cleared");

        // TX with odd parity and two stop bits
        bus_write(4'h4, 8'h07);
        tx_par = 1; tx_odd = 1; tx_stop2 = 1;
        tx_exp.push_back(8'h6E);
        bus_write(4'h0, 8'h6E);
        repeat (12 * 16 + 40) @(negedge clk_i);
        tx_par = 0; tx_odd = 0; tx_stop2 = 0;

        // RX parity and framing errors (0x6E has five ones: even parity bit 1, odd 0)
        bus_write(4'h4, 8'h01);
        send_rx(8'h6E, 16, 1, 0, 1);
        repeat (5) @(negedge clk_i);
        bus_read(4'h1, 8'h27, 8'hFF, "parity_err_status");
        bus_read(4'h2, 8'h6E, 8'hFF, "parity_err_byte_kept");
        bus_read(4'h1, 8'h25, 8'hFF, "parity_err_after_pop");
        send_rx(8'h6E, 16, 1, 1, 0);
        repeat (20) @(negedge clk_i);
        bus_read(4'h1, 8'h35, 8'hFF, "frame_err_no_byte");
        bus_write(4'h1, 8'h30);
        bus_read(4'h1, 8'h05, 8'hFF, "errors_cleared");
        bus_write(4'h4, 8'h03);
        send_rx(8'h6E, 16, 1, 0, 1);
        repeat (5) @(negedge clk_i);
        bus_read(4'h2, 8'h6E, 8'hFF, "odd_parity_byte");
        bus_read(4'h1, 8'h05, 8'hFF, "odd_parity_no_err");
        bus_write(4'h4, 8'h00);

        // RX overrun: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_rx(8'(8'h10 + i), 16, 0, 0, 1);
        repeat (5) @(negedge clk_i);
        bus_read(4'h1, 8'h0F, 8'hFF, "overrun_status");
        for (int i = 0; i < 16; i++) bus_read(4'h2, 8'(8'h10 + i), 8'hFF, "overrun_fifo_data");
        bus_read(4'h1, 8'h0D, 8'hFF, "overrun_fifo_drained");
        bus_write(4'h1, 8'h08);
        bus_read(4'h1, 8'h05, 8'hFF, "overrun_cleared");

        // Divisor 2 is clamped to 4 clks/bit
        set_div(16'd2);
        bus_read(4'h5, 8'h02, 8'hFF, "div_raw_readback");
        tx_div = 4;
        tx_exp.push_back(8'h5A);
        bus_write(4'h0, 8'h5A);
        repeat (60) @(negedge clk_i);
        send_rx(8'hA5, 4, 0, 0, 1);
        repeat (5) @(negedge clk_i);
        bus_read(4'h2, 8'hA5, 8'hFF, "rx_clamped_div");

        // Asynchronous reset in the middle of a TX frame
        set_div(16'd16);
        tx_div = 16;
        send_rx(8'h3C, 16, 0, 0, 1);
        bus_write(4'h3, 8'h01);
        bus_read(4'h5, 8'h10, 8'hFF, "div_before_reset");
        repeat (3) @(negedge clk_i);
        check("irq_before_reset", irq, 1'b1);
        tx_ignore = 1;
        bus_write(4'h0, 8'h33);
        bus_write(4'h0, 8'h44);
        repeat (40) @(negedge clk_i);
        arst_n_i = 1'b0;
        #1;
        check("rst_mid_txd_high", uart_txd_o, 1'b1);
        check("rst_mid_readdata", avms_readdata_o, 8'h00);
        check("rst_mid_irq", irq, 1'b0);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        fs = frames_seen;
        bus_read(4'h1, 8'h05, 8'hFF, "rst_mid_fifos_empty");
        bus_read(4'h2, 8'h00, 8'hFF, "rst_mid_rx_empty");
        bus_read(4'h5, 8'h64, 8'hFF, "rst_mid_div_restored");
        repeat (400) @(negedge clk_i);
        check("rst_mid_no_new_frame", frames_seen, fs);
        check("rst_mid_txd_idle", uart_txd_o, 1'b1);

        repeat (20) @(negedge clk_i);
        check("rd_queue_drained", rd_exp.size(), 0);
        check("tx_queue_drained", tx_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
